// File: rtl/matrix_win_ctrl.sv
// Line-buffer sequencer for a 3x3 window generator: two chained line FIFOs form a
// two-line delay, interior windows are flagged, and both FIFOs are drained per frame.
module matrix_win_ctrl #(
  parameter logic [10:0] IMG_WIDTH  = 11'd640,
  parameter logic [10:0] IMG_HEIGHT = 11'd480
) (
  input  logic        video_clk,
  input  logic        rst_n,
  input  logic        video_vs,
  input  logic        video_de,
  output logic        fifo0_wr_en,
  output logic        fifo0_rd_en,
  output logic        fifo1_wr_en,
  output logic        fifo1_rd_en,
  output logic [10:0] col_cnt,
  output logic [10:0] row_cnt,
  output logic        win_de,
  output logic        frame_done,
  output logic        busy,
  output logic        de_err
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t      state, state_nxt;
  logic        vs_d;
  logic        pend_start;
  logic        aborted;
  logic [10:0] fill0, fill1;
  logic        vs_edge, accept, abort, last_pix, drained, flush_exit;

  assign vs_edge    = video_vs & ~vs_d;
  assign accept     = (state == ACTIVE) && video_de;
  assign abort      = (state == ACTIVE) && vs_edge;
  assign last_pix   = (col_cnt == IMG_WIDTH - 11'd1) && (row_cnt == IMG_HEIGHT - 11'd1);
  // Drained means this cycle's reads empty both line buffers (or they already are).
  assign drained    = ((fill0 - {10'd0, fifo0_rd_en}) == '0) &&
                      ((fill1 - {10'd0, fifo1_rd_en}) == '0);
  assign flush_exit = (state == FLUSH) && drained;

  always_ff @(posedge video_clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vs_edge) state_nxt = ACTIVE;
      ACTIVE:  if (vs_edge || (accept && last_pix)) state_nxt = FLUSH;
      FLUSH:   if (drained) state_nxt = (pend_start || vs_edge) ? ACTIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo0_wr_en = 1'b0;
    fifo0_rd_en = 1'b0;
    fifo1_wr_en = 1'b0;
    fifo1_rd_en = 1'b0;
    if (rst_n) begin
      case (state)
        ACTIVE: if (accept) begin
          fifo0_wr_en = 1'b1;
          fifo0_rd_en = (row_cnt >= 11'd1);
          fifo1_wr_en = (row_cnt >= 11'd1);
          fifo1_rd_en = (row_cnt >= 11'd2);
        end
        FLUSH: begin
          fifo0_rd_en = (fill0 != '0);
          fifo1_rd_en = (fill1 != '0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge video_clk) begin
    if (!rst_n) begin
      vs_d       <= 1'b0;
      fill0      <= '0;
      fill1      <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      pend_start <= 1'b0;
      aborted    <= 1'b0;
      win_de     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      de_err     <= 1'b0;
    end else begin
      vs_d  <= video_vs;
      fill0 <= fill0 + {10'd0, fifo0_wr_en} - {10'd0, fifo0_rd_en};
      fill1 <= fill1 + {10'd0, fifo1_wr_en} - {10'd0, fifo1_rd_en};

      if (abort) begin
        col_cnt <= '0;
        row_cnt <= '0;
      end else if (accept) begin
        if (col_cnt == IMG_WIDTH - 11'd1) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == IMG_HEIGHT - 11'd1) ? '0 : row_cnt + 11'd1;
        end else begin
          col_cnt <= col_cnt + 11'd1;
        end
      end

      if (state != ACTIVE && state_nxt == ACTIVE) pend_start <= 1'b0;
      else if (vs_edge && state != IDLE)          pend_start <= 1'b1;

      if (abort)           aborted <= 1'b1;
      else if (flush_exit) aborted <= 1'b0;

      frame_done <= flush_exit && !aborted;
      win_de     <= accept && (row_cnt >= 11'd2) && (col_cnt >= 11'd2);
      busy       <= (state_nxt != IDLE);

      if (vs_edge)                           de_err <= 1'b0;
      else if (video_de && state != ACTIVE)  de_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_matrix_win_ctrl.sv
// Bench for matrix_win_ctrl on a 5x5 image: vector table for idle/start behaviour,
// scripted frames for normal, gapped, abort, back-to-back and mid-frame reset cases.
module tb_matrix_win_ctrl;
  localparam logic [10:0] W = 11'd5;
  localparam logic [10:0] H = 11'd5;
  localparam int unsigned WI = 5;

  logic        video_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        video_vs = 1'b0;
  logic        video_de = 1'b0;
  logic        fifo0_wr_en, fifo0_rd_en, fifo1_wr_en, fifo1_rd_en;
  logic [10:0] col_cnt, row_cnt;
  logic        win_de, frame_done, busy, de_err;
  logic [3:0]  en_v;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned c_wr0, c_rd0, c_wr1, c_rd1, c_win;
  bit          win_q[$];

  typedef struct {
    bit          vs;
    bit          de;
    logic [3:0]  en;
    bit          busy;
    bit          err;
    int unsigned col;
    int unsigned row;
  } vec_t;
  vec_t tbl[7];

  matrix_win_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .video_clk  (video_clk),
    .rst_n      (rst_n),
    .video_vs   (video_vs),
    .video_de   (video_de),
    .fifo0_wr_en(fifo0_wr_en),
    .fifo0_rd_en(fifo0_rd_en),
    .fifo1_wr_en(fifo1_wr_en),
    .fifo1_rd_en(fifo1_rd_en),
    .col_cnt    (col_cnt),
    .row_cnt    (row_cnt),
    .win_de     (win_de),
    .frame_done (frame_done),
    .busy       (busy),
    .de_err     (de_err)
  );

  assign en_v = {fifo0_wr_en, fifo0_rd_en, fifo1_wr_en, fifo1_rd_en};

  always #5 video_clk = ~video_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, check win_de against the scoreboard, queue
  // the win_de expected on the following cycle, and tally enables.
  task automatic tick(input bit r, input bit vs, input bit de, input bit win_next);
    @(negedge video_clk);
    rst_n    = r;
    video_vs = vs;
    video_de = de;
    #1;
    if (win_q.size() > 0) chk("win_de", 32'(win_de), 32'(win_q.pop_front()));
    win_q.push_back(win_next);
    if (fifo0_wr_en) c_wr0++;
    if (fifo0_rd_en) c_rd0++;
    if (fifo1_wr_en) c_wr1++;
    if (fifo1_rd_en) c_rd1++;
    if (win_de === 1'b1) c_win++;
  endtask

  task automatic pixel(input int unsigned p, input bit check_done, input bit exp_done);
    int unsigned r, c;
    r = p / WI;
    c = p % WI;
    tick(1'b1, 1'b0, 1'b1, (r >= 2 && c >= 2));
    chk("col", 32'(col_cnt), c);
    chk("row", 32'(row_cnt), r);
    chk("busy_px", 32'(busy), 32'(1'b1));
    chk("en_px", 32'(en_v), 32'({1'b1, r >= 1, r >= 1, r >= 2}));
    if (check_done) chk("frame_done_px0", 32'(frame_done), 32'(exp_done));
  endtask

  task automatic run_frame(input bit start_vs, input bit gapped, input bit tail,
                           input bit exp_done_first);
    c_wr0 = 0; c_rd0 = 0; c_wr1 = 0; c_rd1 = 0; c_win = 0;
    if (start_vs) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      chk("busy_start", 32'(busy), 32'(1'b0));
    end
    for (int unsigned p = 0; p < 25; p++) begin
      if (gapped && p > 0) begin
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("col_gap", 32'(col_cnt), p % WI);
        chk("row_gap", 32'(row_cnt), p / WI);
        chk("en_gap", 32'(en_v), 32'(4'b0000));
      end
      pixel(p, (p == 0), (p == 0) && exp_done_first);
    end
    for (int k = 1; k <= 5; k++) begin
      tick(1'b1, tail && (k == 1), tail, 1'b0);
      chk("busy_flush", 32'(busy), 32'(1'b1));
      chk("en_flush", 32'(en_v), 32'(4'b0101));
      chk("done_flush", 32'(frame_done), 32'(1'b0));
      if (tail && k == 2) chk("de_err_clear_wins", 32'(de_err), 32'(1'b0));
      if (tail && k >= 3) chk("de_err_flush", 32'(de_err), 32'(1'b1));
    end
    if (!tail) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      chk("frame_done", 32'(frame_done), 32'(1'b1));
      chk("busy_end", 32'(busy), 32'(1'b0));
      chk("en_end", 32'(en_v), 32'(4'b0000));
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      chk("frame_done_fall", 32'(frame_done), 32'(1'b0));
    end
    chk("n_wr0", c_wr0, 25);
    chk("n_rd0", c_rd0, 25);
    chk("n_wr1", c_wr1, 20);
    chk("n_rd1", c_rd1, 20);
    chk("n_win", c_win, 9);
  endtask

  task automatic check_clean(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(1'b0));
    chk({tag, "_done"}, 32'(frame_done), 32'(1'b0));
    chk({tag, "_err"}, 32'(de_err), 32'(1'b0));
    chk({tag, "_col"}, 32'(col_cnt), 0);
    chk({tag, "_row"}, 32'(row_cnt), 0);
    chk({tag, "_en"}, 32'(en_v), 32'(4'b0000));
  endtask

  initial begin
    // Stray de in IDLE, then vs starts a frame and clears de_err.
    tbl[0] = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 0, 0};
    tbl[1] = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 0, 0};
    tbl[2] = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 0, 0};
    tbl[3] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 0, 0};
    tbl[4] = '{1'b1, 1'b1, 4'b1000, 1'b1, 1'b0, 0, 0};
    tbl[5] = '{1'b0, 1'b1, 4'b1000, 1'b1, 1'b0, 1, 0};
    tbl[6] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2, 0};

    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check_clean("reset");

    for (int i = 0; i < 7; i++) begin
      tick(1'b1, tbl[i].vs, tbl[i].de, 1'b0);
      chk($sformatf("tbl%0d_en", i), 32'(en_v), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_err", i), 32'(de_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_col", i), 32'(col_cnt), tbl[i].col);
      chk($sformatf("tbl%0d_row", i), 32'(row_cnt), tbl[i].row);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check_clean("tbl_reset");

    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(1'b1, 1'b1, 1'b0, 1'b0);

    // Abort after 12 pixels: both line buffers hold a full line.
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int unsigned p = 0; p < 12; p++) pixel(p, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("abort_col", 32'(col_cnt), 2);
    chk("abort_row", 32'(row_cnt), 2);
    for (int k = 1; k <= 5; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      chk("abort_busy", 32'(busy), 32'(1'b1));
      chk("abort_en", 32'(en_v), 32'(4'b0101));
      chk("abort_done", 32'(frame_done), 32'(1'b0));
      chk("abort_col0", 32'(col_cnt), 0);
    end
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: vs and de during the end-of-frame flush.
    run_frame(1'b1, 1'b0, 1'b1, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset for one cycle where pixel 13 would be accepted.
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int unsigned p = 0; p < 13; p++) pixel(p, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_en", 32'(en_v), 32'(4'b0000));
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check_clean("midrst");
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/matrix_win_ctrl.md
# matrix_win_ctrl

Sequencing controller for the two line-buffer FIFOs behind the 3x3 window generator in the video path. It tracks pixel column and row, and drives the write and read enables of both FIFOs so they form a two-line delay. It flags when a complete interior 3x3 window is available, and drains both FIFOs at end of frame or on an aborted frame, so every frame starts with empty line buffers.

## Interface
- IMG_WIDTH, 11'd640: pixels per line; must be >= 3.
- IMG_HEIGHT, 11'd480: lines per frame; must be >= 3.
- video_clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- video_vs  in  1  frame sync; only its rising edge is used.
- video_de  in  1  pixel valid from the source.
- fifo0_wr_en  out  1  push the incoming pixel into line FIFO 0.
- fifo0_rd_en  out  1  pop line FIFO 0, giving the row r-1 pixel.
- fifo1_wr_en  out  1  push the FIFO 0 output into line FIFO 1.
- fifo1_rd_en  out  1  pop line FIFO 1, giving the row r-2 pixel.
- col_cnt  out  11  column of the next pixel to accept (registered).
- row_cnt  out  11  row of the next pixel to accept (registered).
- win_de  out  1  registered; a full interior 3x3 window is on the datapath.
- frame_done  out  1  one-cycle pulse after a complete frame has drained.
- busy  out  1  registered; high in ACTIVE or FLUSH.
- de_err  out  1  sticky; video_de was seen while not ACTIVE.

## Operation
- **States.** IDLE, ACTIVE, FLUSH.
- **vs edge detect.** vs_d is a registered copy of video_vs; an edge is video_vs & ~vs_d.
- **Accept.** A pixel is accepted when state==ACTIVE && video_de. Enables are combinational from accept, the state and registered counts, so the FIFO write lands in the same cycle as the pixel.
- **ACTIVE, on accept:**
  - fifo0_wr_en=1.
  - If row_cnt>=1: fifo0_rd_en=1 and fifo1_wr_en=1.
  - If row_cnt>=2: fifo1_rd_en=1.
  - col_cnt increments; at IMG_WIDTH-1 it wraps to 0 and row_cnt increments.
  - Accepting the pixel (IMG_HEIGHT-1, IMG_WIDTH-1) sets row_cnt/col_cnt to 0 and moves to FLUSH.
- **Fill counters.** Internal counters fill0 and fill1 (11 bits) track FIFO occupancy: +1 on wr, -1 on rd, net 0 when both happen together. Neither may exceed IMG_WIDTH.
- **FLUSH:**
  - fifo0_rd_en = (fill0!=0) and fifo1_rd_en = (fill1!=0).
  - Both wr enables are 0 and video_de is ignored.
  - When the cycle's reads bring both fills to 0, or both are already 0, the next state is ACTIVE if pend_start is set, otherwise IDLE.
  - frame_done pulses on that transition unless the flush came from an abort.
- **Start and abort:**
  - vs edge in IDLE: go to ACTIVE next cycle.
  - vs edge in ACTIVE: abort. Counters go to 0, state goes to FLUSH, pend_start=1, and frame_done is suppressed for this flush.
  - vs edge in FLUSH: pend_start=1.
  - pend_start clears on entry to ACTIVE.
- **de_err.** Set by video_de=1 in IDLE or FLUSH. Cleared on the cycle a vs edge is detected; if both happen in the same cycle, clear wins.
- **win_de.** Registered version of (accept && row_cnt>=2 && col_cnt>=2).
- **Window count.** A full frame produces exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) win_de pulses. Border windows are never flagged.

## Timing
- **Reset.** On the first video_clk edge with rst_n=0:
  - state=IDLE; col_cnt=row_cnt=0; fill0=fill1=0; vs_d=0.
  - pend_start=0; win_de=frame_done=busy=de_err=0.
  - All FIFO enables are 0 while in reset.
  - The line FIFOs must share rst_n; a reset mid-frame discards their contents.
- **Start latency.** A vs edge sampled at cycle t gives ACTIVE at t+1, and a pixel is first accepted at t+1.
- **win_de latency.** win_de rises exactly 1 cycle after the accept that completes the window.
- **End of frame.** With the last pixel accepted at cycle t:
  - FLUSH spans t+1..t+IMG_WIDTH, and both rd enables are high throughout.
  - State is IDLE and frame_done=1 at t+IMG_WIDTH+1.
- **Gapped video_de** stalls the counters and enables only; no timeouts.
- **Counter width.** Counters are 11 bits and never wrap past IMG_WIDTH-1 or IMG_HEIGHT-1.

## Test plan
With IMG_WIDTH=IMG_HEIGHT=5:
- **Normal frame.** vs pulse, then 25 continuous de cycles.
  - Required: win_de high 9 times, the first 1 cycle after pixel (2,2).
  - Write/read counts: fifo0_wr=25, fifo0_rd=25, fifo1_wr=20, fifo1_rd=20.
  - FLUSH lasts 5 cycles and frame_done pulses 6 cycles after the last pixel.
- **Gapped de.** 25 pixels with de alternating 1/0.
  - Required: same totals as the normal frame.
  - col/row advance only on de=1 cycles, and win_de follows each qualifying pixel by 1 cycle.
- **Abort.** vs edge after 12 accepted pixels (row 2, col 2 next).
  - Required: FLUSH with fill0=fill1=5, so 5 read cycles on both FIFOs.
  - No frame_done; then ACTIVE with counters at 0.
- **Stray de.** de=1 for 3 cycles in IDLE.
  - Required: all enables stay 0 and de_err=1.
  - The next vs edge clears de_err and starts the frame.
- **Back-to-back.** vs edge during the normal-end FLUSH, with de held high.
  - Required: pixels in FLUSH are ignored and de_err=1.
  - ACTIVE directly follows the flush with frame_done pulsing once, and the next frame runs normally.
- **Reset mid-frame.** rst_n=0 for 1 cycle at pixel 13.
  - Required: the next cycle shows IDLE, all outputs 0 and busy=0.
  - The following vs edge starts a clean frame.
